// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-subset datapath.
// Outputs decode the current state; reset gates every strobe low and parks the selects at FETCH values.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       ext_zero,
    output logic       illegal,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11
    } state_t;

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b100111, 6'b101010: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic [3:0] imm_alu(input logic [5:0] op);
        case (op)
            6'b001100: return 4'b0000;
            6'b001101: return 4'b0001;
            6'b001010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_alu_control;
    logic [1:0] w_alu_src_b, w_pc_source;
    logic       w_pc_write, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
    logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_ext_zero, w_illegal;
    logic       w_logical_imm;

    assign w_logical_imm = (opcode == 6'b001100) || (opcode == 6'b001101);

    // State register; reset overrides next-state logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; unused codes fall back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'b100011, 6'b101011:                        w_next = S_MEMADR;
                    6'b000000:                                   w_next = funct_ok(funct) ? S_EXEC : S_FETCH;
                    6'b000100, 6'b000101:                        w_next = S_BRANCH;
                    6'b000010:                                   w_next = S_JUMP;
                    6'b001000, 6'b001100, 6'b001101, 6'b001010:  w_next = S_IEXEC;
                    default:                                     w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_ALUWB;
            S_IEXEC:  w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls before reset gating.
    always_comb begin
        w_alu_control = 4'b0000;
        w_alu_src_b   = 2'b00;
        w_pc_source   = 2'b00;
        w_pc_write    = 1'b0;
        w_i_or_d      = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_dst     = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_a   = 1'b0;
        w_ext_zero    = 1'b0;
        w_illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1; w_ir_write = 1'b1; w_pc_write = 1'b1;
                w_alu_src_b = 2'b01; w_alu_control = 4'b0010;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11; w_alu_control = 4'b0010;
                case (opcode)
                    6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                    6'b001000, 6'b001100, 6'b001101, 6'b001010: w_illegal = 1'b0;
                    6'b000000:                                  w_illegal = ~funct_ok(funct);
                    default:                                    w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1; w_alu_src_b = 2'b10; w_alu_control = 4'b0010;
            end
            S_MEMRD:  begin w_mem_read = 1'b1; w_i_or_d = 1'b1; end
            S_MEMWB:  begin w_reg_write = 1'b1; w_mem_to_reg = 1'b1; end
            S_MEMWR:  begin w_mem_write = 1'b1; w_i_or_d = 1'b1; end
            S_EXEC: begin
                w_alu_src_a = 1'b1; w_alu_control = funct_alu(funct);
            end
            S_ALUWB:  begin w_reg_dst = 1'b1; w_reg_write = 1'b1; end
            S_BRANCH: begin
                w_alu_src_a = 1'b1; w_alu_control = 4'b0110; w_pc_source = 2'b01;
                w_pc_write  = (opcode == 6'b000100) ? zero :
                              (opcode == 6'b000101) ? ~zero : 1'b0;
            end
            S_JUMP:   begin w_pc_source = 2'b10; w_pc_write = 1'b1; end
            S_IEXEC: begin
                w_alu_src_a = 1'b1; w_alu_src_b = 2'b10;
                w_alu_control = imm_alu(opcode); w_ext_zero = w_logical_imm;
            end
            S_IWB: begin
                w_reg_write = 1'b1; w_alu_control = imm_alu(opcode); w_ext_zero = w_logical_imm;
            end
            default: w_illegal = 1'b0;
        endcase
    end

    // While reset is high, strobes are suppressed and selects show FETCH values.
    assign pc_write    = w_pc_write  & ~reset;
    assign mem_read    = w_mem_read  & ~reset;
    assign mem_write   = w_mem_write & ~reset;
    assign ir_write    = w_ir_write  & ~reset;
    assign reg_write   = w_reg_write & ~reset;
    assign illegal     = w_illegal   & ~reset;
    assign alu_control = reset ? 4'b0010 : w_alu_control;
    assign alu_src_b   = reset ? 2'b01   : w_alu_src_b;
    assign pc_source   = reset ? 2'b00   : w_pc_source;
    assign i_or_d      = reset ? 1'b0    : w_i_or_d;
    assign mem_to_reg  = reset ? 1'b0    : w_mem_to_reg;
    assign reg_dst     = reset ? 1'b0    : w_reg_dst;
    assign alu_src_a   = reset ? 1'b0    : w_alu_src_a;
    assign ext_zero    = reset ? 1'b0    : w_ext_zero;
    assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its state sequence.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0;
    logic [3:0] alu_control, state;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, ext_zero, illegal;
    logic [1:0] alu_src_b, pc_source;
    int         n_cmp = 0;
    int         n_err = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_control(alu_control), .pc_write(pc_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .ext_zero(ext_zero), .illegal(illegal),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
        n_cmp++; if ({pc_write, mem_read, ir_write, mem_write, reg_write, illegal} !== 6'b0) begin n_err++; $display("FAIL rst_strobes: got %b want 000000", {pc_write, mem_read, ir_write, mem_write, reg_write, illegal}); end
        n_cmp++; if ({alu_src_b, alu_control, pc_source} !== 8'b01_0010_00) begin n_err++; $display("FAIL rst_selects: got %b want 01001000", {alu_src_b, alu_control, pc_source}); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({state, mem_read, ir_write, pc_write} !== 7'b0000_111) begin n_err++; $display("FAIL post_rst_fetch: got %b want 0000111", {state, mem_read, ir_write, pc_write}); end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'b100011; #1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (state !== exp_st[i]) begin n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            n_cmp++; if ({reg_write, mem_to_reg} !== ((i == 4) ? 2'b11 : 2'b00)) begin n_err++; $display("FAIL lw_wb[%0d]: got %b", i, {reg_write, mem_to_reg}); end
            if (i == 2) begin
                n_cmp++; if ({alu_src_a, alu_src_b, alu_control} !== 7'b1_10_0010) begin n_err++; $display("FAIL lw_memadr: got %b want 1100010", {alu_src_a, alu_src_b, alu_control}); end
            end
            if (i == 3) begin
                n_cmp++; if ({mem_read, i_or_d} !== 2'b11) begin n_err++; $display("FAIL lw_memrd: got %b want 11", {mem_read, i_or_d}); end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_rtype(input logic [5:0] f, input logic [3:0] exp_alu);
        opcode = 6'b000000; funct = f; #1;
        tick();
        n_cmp++; if ({state, illegal, alu_src_b} !== {4'd1, 1'b0, 2'b11}) begin n_err++; $display("FAIL r_decode: got %b want 0001011", {state, illegal, alu_src_b}); end
        tick();
        n_cmp++; if ({state, alu_control, alu_src_a, alu_src_b} !== {4'd6, exp_alu, 1'b1, 2'b00}) begin n_err++; $display("FAIL r_exec f=%b: got %b want %b", f, {state, alu_control, alu_src_a, alu_src_b}, {4'd6, exp_alu, 1'b1, 2'b00}); end
        tick();
        n_cmp++; if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd7, 3'b110}) begin n_err++; $display("FAIL r_aluwb: got %b want 0111110", {state, reg_write, reg_dst, mem_to_reg}); end
        tick();
        n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL r_return: got %0d want 0", state); end
    endtask

    task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_pcw);
        opcode = op; zero = z; #1;
        tick(); tick();
        n_cmp++; if ({state, pc_write, pc_source, alu_control, alu_src_a} !== {4'd8, exp_pcw, 2'b01, 4'b0110, 1'b1}) begin n_err++; $display("FAIL branch op=%b z=%b: got %b want %b", op, z, {state, pc_write, pc_source, alu_control, alu_src_a}, {4'd8, exp_pcw, 2'b01, 4'b0110, 1'b1}); end
        tick();
        n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL branch_return: got %0d want 0", state); end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        opcode = 6'b000010; #1;
        tick(); tick();
        n_cmp++; if ({state, pc_write, pc_source} !== {4'd9, 1'b1, 2'b10}) begin n_err++; $display("FAIL jump: got %b want 1001110", {state, pc_write, pc_source}); end
        tick();
        n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL jump_return: got %0d want 0", state); end
    endtask

    task automatic test_illegal(input logic [5:0] op, input logic [5:0] f);
        opcode = op; funct = f; #1;
        tick();
        n_cmp++; if ({state, illegal, reg_write, mem_write, pc_write} !== {4'd1, 4'b1000}) begin n_err++; $display("FAIL illegal_decode op=%b: got %b want 00011000", op, {state, illegal, reg_write, mem_write, pc_write}); end
        tick();
        n_cmp++; if ({state, illegal} !== {4'd0, 1'b0}) begin n_err++; $display("FAIL illegal_return op=%b: got %b want 00000", op, {state, illegal}); end
    endtask

    task automatic test_sw_reset();
        opcode = 6'b101011; #1;
        tick(); tick(); tick();
        n_cmp++; if ({state, mem_write, i_or_d} !== {4'd5, 2'b11}) begin n_err++; $display("FAIL sw_memwr: got %b want 010111", {state, mem_write, i_or_d}); end
        reset = 1'b1; #1;
        n_cmp++; if ({mem_write, i_or_d} !== 2'b00) begin n_err++; $display("FAIL sw_rst_gate: got %b want 00", {mem_write, i_or_d}); end
        tick();
        n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL sw_rst_state: got %0d want 0", state); end
        reset = 1'b0; #1;
        n_cmp++; if ({state, mem_read, ir_write} !== {4'd0, 2'b11}) begin n_err++; $display("FAIL sw_rst_fetch: got %b want 000011", {state, mem_read, ir_write}); end
    endtask

    task automatic test_imm(input logic [5:0] op, input logic [3:0] exp_alu, input logic exp_ez);
        opcode = op; #1;
        tick(); tick();
        n_cmp++; if ({state, alu_control, ext_zero, alu_src_a, alu_src_b, reg_write} !== {4'd10, exp_alu, exp_ez, 1'b1, 2'b10, 1'b0}) begin n_err++; $display("FAIL iexec op=%b: got %b want %b", op, {state, alu_control, ext_zero, alu_src_a, alu_src_b, reg_write}, {4'd10, exp_alu, exp_ez, 1'b1, 2'b10, 1'b0}); end
        tick();
        n_cmp++; if ({state, reg_write, reg_dst, mem_to_reg, alu_control, ext_zero} !== {4'd11, 3'b100, exp_alu, exp_ez}) begin n_err++; $display("FAIL iwb op=%b: got %b want %b", op, {state, reg_write, reg_dst, mem_to_reg, alu_control, ext_zero}, {4'd11, 3'b100, exp_alu, exp_ez}); end
        tick();
        n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL imm_return: got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype(6'b101010, 4'b0111);
        test_rtype(6'b100010, 4'b0110);
        test_rtype(6'b100111, 4'b1100);
        test_branch(6'b000100, 1'b1, 1'b1);
        test_branch(6'b000100, 1'b0, 1'b0);
        test_branch(6'b000101, 1'b1, 1'b0);
        test_branch(6'b000101, 1'b0, 1'b1);
        test_jump();
        test_illegal(6'b111111, 6'b000000);
        test_illegal(6'b000000, 6'b000001);
        test_sw_reset();
        test_imm(6'b001101, 4'b0001, 1'b1);
        test_imm(6'b001000, 4'b0010, 1'b0);
        test_imm(6'b001010, 4'b0111, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL: opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-004 SHALL: funct  input  6  instruction bits [5:0] from the instruction register.
REQ-005 SHALL: zero  input  1  ALU zero flag, valid in the same cycle as alu_control.
REQ-006 SHALL: alu_control  output  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-007 SHALL: pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero, illegal  output  1 each  datapath strobes and selects.
REQ-008 SHALL: alu_src_b  output  2  00 reg B, 01 constant 4, 10 extended imm, 11 sign-extended imm<<2.
REQ-009 SHALL: pc_source  output  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-010 SHALL: state  output  4  current state code, for debug and verification.

Function
REQ-011 SHALL: Moore FSM; states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11; codes 12-15 unreachable, go to FETCH.
REQ-012 SHALL: outputs depend only on state; opcode/funct/zero only affect outputs where stated below; unlisted strobes 0, unlisted selects 0.
REQ-013 SHALL: FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_control=0010, pc_write=1, pc_source=00; next DECODE.
REQ-014 SHALL: DECODE: alu_src_b=11, alu_control=0010 (branch target precompute); next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100/000101 -> BRANCH, 000010 -> JUMP, 001000/001100/001101/001010 -> IEXEC, other -> FETCH.
REQ-015 SHALL: MEMADR: alu_src_a=1, alu_src_b=10, alu_control=0010; next MEMRD if opcode=100011 else MEMWR.
REQ-016 SHALL: MEMRD: mem_read=1, i_or_d=1 -> MEMWB; MEMWB: reg_write=1, mem_to_reg=1 -> FETCH; MEMWR: mem_write=1, i_or_d=1 -> FETCH.
REQ-017 SHALL: EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 100111 -> 1100, 101010 -> 0111; next ALUWB.
REQ-018 SHALL: ALUWB: reg_dst=1, reg_write=1 -> FETCH.
REQ-019 SHALL: BRANCH: alu_src_a=1, alu_src_b=00, alu_control=0110, pc_source=01; pc_write=zero for 000100, pc_write=~zero for 000101; next FETCH.
REQ-020 SHALL: JUMP: pc_source=10, pc_write=1 -> FETCH.
REQ-021 SHALL: IEXEC: alu_src_a=1, alu_src_b=10; alu_control 001000 -> 0010, 001100 -> 0000, 001101 -> 0001, 001010 -> 0111; ext_zero=1 for 001100/001101 only; next IWB.
REQ-022 SHALL: IWB: reg_write=1, reg_dst=0, mem_to_reg=0, plus IEXEC alu_control/ext_zero held -> FETCH.
REQ-023 SHALL: illegal=1 for exactly the DECODE cycle when opcode unsupported, or opcode=000000 with funct unsupported; such an instruction returns to FETCH with no reg_write/mem_write/pc_write beyond FETCH.
REQ-024 SHALL: cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, I-ALU 4, beq/bne 3, j 3, illegal 2.
REQ-025 SHALL: opcode/funct assumed stable from DECODE to end of instruction (IR written only in FETCH).

Reset
REQ-026 SHALL: reset=1 at rising edge forces state=FETCH next cycle, regardless of current state, and overrides the next-state logic.
REQ-027 SHALL: while reset=1, pc_write, mem_read, mem_write, ir_write, reg_write, illegal forced 0; selects take FETCH values.
REQ-028 SHALL: first cycle after reset deasserts is FETCH with its normal outputs.

Verification
REQ-029 SHALL: reset, opcode=100011 -> state 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-030 SHALL: opcode=000000, funct=101010 -> state 6 drives alu_control=0111; state 7 reg_write=1, reg_dst=1.
REQ-031 SHALL: opcode=000100 with zero=1 -> pc_write=1 in state 8; opcode=000101 with zero=1 -> pc_write=0 in state 8.
REQ-032 SHALL: opcode=111111 -> illegal=1 in state 1 only, next state 0, no reg_write/mem_write.
REQ-033 SHALL: reset pulsed in MEMWR during sw -> mem_write=0 that cycle, state 0 next cycle.
REQ-034 SHALL: opcode=001101 -> state 10 alu_control=0001, ext_zero=1; state 11 reg_write=1, reg_dst=0.
